// File: rtl/tc77_temp_monitor.sv
// TC77 poller: reads the sensor over its 3-wire bus and turns each accepted
// reading into the heater-wait release (nTEMPLO) and the fan enable (nFANEN).
module tc77_temp_monitor #(
  parameter int unsigned CLK_DIV     = 12,
  parameter int unsigned POLL_CYCLES = 19200000,
  parameter int          FAN_ON      = 720,
  parameter int          FAN_OFF     = 640,
  parameter bit          CHECK_FLAG  = 1'b1
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic        nSYSOK,
  input  logic [2:0]  TEMPSW,
  input  logic        FORCEBOOT,
  output logic        nTEMPCS,
  output logic        TEMPCLK,
  input  logic        TEMPSIO,
  output logic        nTEMPLO,
  output logic        nFANEN,
  output logic [12:0] TEMPDATA,
  output logic        TEMPVALID
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned POLL_W = $clog2(POLL_CYCLES + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
  localparam logic signed [12:0] FAN_ON_S  = 13'(FAN_ON);
  localparam logic signed [12:0] FAN_OFF_S = 13'(FAN_OFF);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SETUP, S_SHIFT, S_HOLD, S_EVAL
  } state_t;

  state_t              state_q, state_d;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [3:0]          bit_q, bit_d;
  logic [15:0]         sreg_q, sreg_d;
  logic                cs_d, sclk_d, templo_d, fanen_d, valid_d;
  logic [12:0]         data_d;

  logic                div_last_c;
  logic                accept_c;
  logic signed [12:0]  temp_c;
  logic signed [12:0]  rel_thr_c;

  assign div_last_c = (div_q == DIV_LAST);
  assign accept_c   = !CHECK_FLAG || sreg_q[2];
  assign temp_c     = sreg_q[15:3];
  assign rel_thr_c  = 13'(TEMPSW) * 13'd80;

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_d  = state_q;
    poll_d   = poll_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sreg_d   = sreg_q;
    cs_d     = nTEMPCS;
    sclk_d   = TEMPCLK;
    templo_d = nTEMPLO;
    fanen_d  = nFANEN;
    data_d   = TEMPDATA;
    valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        poll_d = '0;
        if (!nSYSOK) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (poll_q == POLL_LAST) begin
          poll_d  = '0;
          div_d   = '0;
          cs_d    = 1'b0;
          state_d = S_SETUP;
        end else begin
          poll_d = poll_q + POLL_W'(1);
        end
      end
      S_SETUP: begin
        if (div_last_c) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_SHIFT: begin
        if (!div_last_c) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (!TEMPCLK) begin
            // Sample on the edge where TEMPCLK is driven high.
            sclk_d = 1'b1;
            sreg_d = {sreg_q[14:0], TEMPSIO};
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 4'd1;
            if (bit_q == 4'd15) state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (div_last_c) begin
          div_d   = '0;
          cs_d    = 1'b1;
          state_d = S_EVAL;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_EVAL: begin
        poll_d  = '0;
        state_d = S_WAIT;
        if (accept_c) begin
          data_d  = sreg_q[15:3];
          valid_d = 1'b1;
          if (temp_c >= FAN_ON_S)       fanen_d = 1'b0;
          else if (temp_c <= FAN_OFF_S) fanen_d = 1'b1;
          if (TEMPSW == 3'd7 || temp_c >= rel_thr_c) templo_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!nSYSOK && FORCEBOOT) templo_d = 1'b1;

    // Power-not-good overrides everything except the last reading.
    if (nSYSOK) begin
      state_d  = S_IDLE;
      poll_d   = '0;
      div_d    = '0;
      bit_d    = '0;
      cs_d     = 1'b1;
      sclk_d   = 1'b0;
      templo_d = 1'b0;
      fanen_d  = 1'b1;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= S_IDLE;
      poll_q    <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      sreg_q    <= '0;
      nTEMPCS   <= 1'b1;
      TEMPCLK   <= 1'b0;
      nTEMPLO   <= 1'b0;
      nFANEN    <= 1'b1;
      TEMPDATA  <= '0;
      TEMPVALID <= 1'b0;
    end else begin
      state_q   <= state_d;
      poll_q    <= poll_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sreg_q    <= sreg_d;
      nTEMPCS   <= cs_d;
      TEMPCLK   <= sclk_d;
      nTEMPLO   <= templo_d;
      nFANEN    <= fanen_d;
      TEMPDATA  <= data_d;
      TEMPVALID <= valid_d;
    end
  end

endmodule

// File: tb/tb_tc77_temp_monitor.sv
// Bench for tc77_temp_monitor: a TC77 bus model feeds readings and an
// arithmetic reference model predicts data, fan and release behaviour.
module tb_tc77_temp_monitor;

  localparam int unsigned CLK_DIV     = 2;
  localparam int unsigned POLL_CYCLES = 100;
  localparam int          FAN_ON      = 720;
  localparam int          FAN_OFF     = 640;

  logic        MCLK = 1'b0;
  logic        nRESET, nSYSOK, FORCEBOOT, TEMPSIO;
  logic [2:0]  TEMPSW;
  logic        nTEMPCS, TEMPCLK, nTEMPLO, nFANEN, TEMPVALID;
  logic [12:0] TEMPDATA;
  logic        nf_cs, nf_sclk, nf_lo, nf_fan, nf_valid;
  logic [12:0] nf_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] sensor_word = 16'h0;
  logic [15:0] sio_sr = 16'h0;
  int          edges = 0;

  logic [12:0] m_data;
  logic        m_fan, m_lo;

  always #5 MCLK = ~MCLK;

  tc77_temp_monitor #(
    .CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL_CYCLES),
    .FAN_ON(FAN_ON), .FAN_OFF(FAN_OFF), .CHECK_FLAG(1'b1)
  ) dut (
    .MCLK(MCLK), .nRESET(nRESET), .nSYSOK(nSYSOK), .TEMPSW(TEMPSW),
    .FORCEBOOT(FORCEBOOT), .nTEMPCS(nTEMPCS), .TEMPCLK(TEMPCLK),
    .TEMPSIO(TEMPSIO), .nTEMPLO(nTEMPLO), .nFANEN(nFANEN),
    .TEMPDATA(TEMPDATA), .TEMPVALID(TEMPVALID)
  );

  tc77_temp_monitor #(
    .CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL_CYCLES),
    .FAN_ON(FAN_ON), .FAN_OFF(FAN_OFF), .CHECK_FLAG(1'b0)
  ) dut_nf (
    .MCLK(MCLK), .nRESET(nRESET), .nSYSOK(nSYSOK), .TEMPSW(TEMPSW),
    .FORCEBOOT(FORCEBOOT), .nTEMPCS(nf_cs), .TEMPCLK(nf_sclk),
    .TEMPSIO(TEMPSIO), .nTEMPLO(nf_lo), .nFANEN(nf_fan),
    .TEMPDATA(nf_data), .TEMPVALID(nf_valid)
  );

  // Sensor: load the word at chip select, present the next bit after each rise.
  always @(negedge nTEMPCS or posedge TEMPCLK) begin
    if (!TEMPCLK) begin
      sio_sr = sensor_word;
      edges  = 0;
    end else begin
      sio_sr = {sio_sr[14:0], 1'b0};
      edges  = edges + 1;
    end
  end
  assign TEMPSIO = sio_sr[15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk_word(input int t, input bit flag);
    return {13'(t), flag, 2'b00};
  endfunction

  function automatic void model_read(input logic [15:0] w, input logic [2:0] sw,
                                     input bit flag_chk, inout logic [12:0] d,
                                     inout logic fan, inout logic lo, output bit acc);
    int t;
    t   = w[15] ? int'(w[15:3]) - 8192 : int'(w[15:3]);
    acc = !flag_chk || w[2];
    if (acc) begin
      d = w[15:3];
      if (t >= FAN_ON)       fan = 1'b0;
      else if (t <= FAN_OFF) fan = 1'b1;
      if (sw == 3'd7 || t >= int'(sw) * 80) lo = 1'b1;
    end
  endfunction

  task automatic model_reset();
    m_data = '0;
    m_fan  = 1'b1;
    m_lo   = 1'b0;
  endtask

  // One full poll: wait for chip select, check the frame, then the EVAL result.
  task automatic do_read(input logic [15:0] w, output int wait_cyc);
    int          n;
    int          vcnt;
    logic [12:0] vdata;
    logic        vlo;
    bit          acc;
    sensor_word = w;
    wait_cyc = 0;
    while (nTEMPCS !== 1'b0 && wait_cyc < 400) begin
      @(negedge MCLK);
      wait_cyc++;
    end
    if (nTEMPCS !== 1'b0) begin
      chk("cs_fall_timeout", 32'd0, 32'd1);
      return;
    end
    n = 0;
    while (nTEMPCS === 1'b0 && n < 200) begin
      @(negedge MCLK);
      n++;
    end
    chk("cs_low_cycles", n, 34 * CLK_DIV);
    chk("tempclk_rises", edges, 16);
    chk("lo_during_eval", nTEMPLO, m_lo);
    model_read(w, TEMPSW, 1'b1, m_data, m_fan, m_lo, acc);
    vcnt  = 0;
    vdata = 'x;
    vlo   = 1'bx;
    for (int i = 0; i < 4; i++) begin
      @(negedge MCLK);
      if (TEMPVALID === 1'b1) begin
        vcnt++;
        vdata = TEMPDATA;
        vlo   = nTEMPLO;
      end
    end
    chk("valid_pulses", vcnt, acc ? 1 : 0);
    if (acc) begin
      chk("data_at_valid", vdata, m_data);
      chk("lo_at_valid", vlo, m_lo);
    end
    chk("tempdata", TEMPDATA, m_data);
    chk("nfanen", nFANEN, m_fan);
    chk("ntemplo", nTEMPLO, m_lo);
  endtask

  task automatic sysok_pulse();
    @(negedge MCLK);
    nSYSOK = 1'b1;
    @(negedge MCLK);
    @(negedge MCLK);
    nSYSOK = 1'b0;
    m_lo  = 1'b0;
    m_fan = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          wc;
    int          n;
    int          seq[7];
    logic [12:0] nd;
    logic        nfan, nlo;
    bit          acc;

    nRESET = 1'b0; nSYSOK = 1'b1; FORCEBOOT = 1'b0; TEMPSW = 3'd0;
    model_reset();
    #23;
    chk("rst_ncs", nTEMPCS, 1);
    chk("rst_sclk", TEMPCLK, 0);
    chk("rst_lo", nTEMPLO, 0);
    chk("rst_fan", nFANEN, 1);
    chk("rst_data", TEMPDATA, 0);
    chk("rst_valid", TEMPVALID, 0);
    @(negedge MCLK);
    nRESET = 1'b1;
    @(negedge MCLK);
    nSYSOK = 1'b0;

    // Flag clear: rejected by the checking instance, accepted by the other.
    TEMPSW = 3'd4;
    do_read(16'h0C80, wc);
    nd = '0; nfan = 1'b1; nlo = 1'b0;
    model_read(16'h0C80, TEMPSW, 1'b0, nd, nfan, nlo, acc);
    chk("nf_tempdata", nf_data, nd);
    chk("nf_lo", nf_lo, nlo);
    chk("nf_fan", nf_fan, nfan);
    sysok_pulse();

    // 25 C against 20 C threshold, then exactly at a 25 C threshold.
    TEMPSW = 3'd4;
    do_read(16'h0C84, wc);
    sysok_pulse();
    TEMPSW = 3'd5;
    do_read(mk_word(400, 1'b1), wc);
    TEMPSW = 3'd6;
    do_read(mk_word(420, 1'b1), wc);

    // Fan hysteresis sweep including both thresholds exactly.
    seq = '{736, 672, 624, 720, 641, 640, 730};
    foreach (seq[i]) do_read(mk_word(seq[i], 1'b1), wc);

    // Drop power-good after the 7th serial clock rise.
    sensor_word = mk_word(500, 1'b1);
    n = 0;
    while (nTEMPCS !== 1'b0 && n < 400) begin @(negedge MCLK); n++; end
    n = 0;
    while (edges < 7 && n < 100) begin @(negedge MCLK); n++; end
    chk("abort_at_7th_edge", edges, 7);
    nSYSOK = 1'b1;
    @(negedge MCLK);
    chk("abort_ncs", nTEMPCS, 1);
    chk("abort_sclk", TEMPCLK, 0);
    chk("abort_lo", nTEMPLO, 0);
    chk("abort_fan", nFANEN, 1);
    chk("abort_data_kept", TEMPDATA, m_data);
    m_lo = 1'b0; m_fan = 1'b1;
    @(negedge MCLK);
    @(negedge MCLK);
    nSYSOK = 1'b0;
    do_read(mk_word(500, 1'b1), wc);
    chk("poll_gap", (wc >= POLL_CYCLES && wc <= POLL_CYCLES + 1), 1);

    // Negative reading: held for code 0, released by code 7 and by FORCEBOOT.
    sysok_pulse();
    TEMPSW = 3'd0;
    do_read(16'hFD84, wc);
    TEMPSW = 3'd7;
    do_read(16'hFD84, wc);
    sysok_pulse();
    TEMPSW = 3'd0;
    do_read(16'hFD84, wc);
    @(negedge MCLK);
    FORCEBOOT = 1'b1;
    @(negedge MCLK);
    chk("forceboot_lo", nTEMPLO, 1);
    FORCEBOOT = 1'b0;
    m_lo = 1'b1;
    do_read(16'hFD84, wc);

    // Asynchronous reset between clock edges mid-frame.
    sensor_word = mk_word(300, 1'b1);
    n = 0;
    while (nTEMPCS !== 1'b0 && n < 400) begin @(negedge MCLK); n++; end
    n = 0;
    while (edges < 3 && n < 100) begin @(negedge MCLK); n++; end
    @(posedge MCLK);
    #2 nRESET = 1'b0;
    #1;
    chk("arst_ncs", nTEMPCS, 1);
    chk("arst_sclk", TEMPCLK, 0);
    chk("arst_lo", nTEMPLO, 0);
    chk("arst_fan", nFANEN, 1);
    chk("arst_data", TEMPDATA, 0);
    chk("arst_valid", TEMPVALID, 0);
    model_reset();
    @(negedge MCLK);
    nRESET = 1'b1;
    TEMPSW = 3'd3;
    do_read(mk_word(300, 1'b1), wc);

    // Randomized readings, flags and threshold codes.
    for (int r = 0; r < 12; r++) begin
      int          t;
      logic [12:0] t13;
      logic [15:0] w;
      t   = int'($urandom_range(1200)) - 200;
      t13 = 13'(t);
      w   = {t13, ($urandom_range(3) != 0), 2'($urandom)};
      TEMPSW = 3'($urandom_range(7));
      if ($urandom_range(4) == 0) sysok_pulse();
      do_read(w, wc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
